// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small circular-buffer FIFO; frames go out back-to-back.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
`default_nettype none

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 900,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
    logic            parity;
`endif

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic            baud_last;
    logic [7:0]      head;

    assign tx_ready   = (count != DEPTH_C);
    assign push       = tx_valid && tx_ready;
    assign baud_last  = (baud == BAUD_LAST);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    // Pop when idle, or on the last stop cycle so the next start bit follows without a gap.
    assign pop = (count != '0) &&
                 ((state == S_IDLE) || ((state == S_STOP) && baud_last));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // tx is registered from the current state, so the line trails the state by one clock;
    // every bit still lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            busy <= push || (count != '0) || (state != S_IDLE);
            baud <= baud + BW'(1);
            case (state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (pop) begin
                        shift <= head;
`ifdef UART_TX_PARITY_EN
                        parity <= ^head;
`endif
                        state <= S_START;
                    end
                end
                S_START: begin
                    tx <= 1'b0;
                    if (baud_last) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    tx <= shift[0];
                    if (baud_last) begin
                        baud    <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    tx <= parity;
                    if (baud_last) begin
                        baud  <= '0;
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    tx <= 1'b1;
                    if (baud_last) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= head;
`ifdef UART_TX_PARITY_EN
                            parity <= ^head;
`endif
                            state <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    baud  <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo (short bit time to keep runs brief).
`default_nettype none

module tb_uart_tx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int checks = 0;
    int failures = 0;
    bit found;
    int waited;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge; the byte is sampled by the following posedge.
    task automatic drive_push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_start(input int limit, output bit f, output int w);
        w = 0;
        @(negedge clk);
        while (tx !== 1'b0 && w < limit) begin
            w++;
            @(negedge clk);
        end
        f = (tx === 1'b0);
    endtask

    // Entered on the first cycle of a start bit; checks first and last cycle of every bit.
    task automatic check_frame(input logic [7:0] b, input string tag);
        for (int k = 0; k < NB; k++) begin
            chk($sformatf("%s_b%0d_first", tag, k), tx, exp_bit(b, k));
            chk($sformatf("%s_b%0d_busy", tag, k), busy, 1);
            repeat (CPB - 1) @(negedge clk);
            chk($sformatf("%s_b%0d_last", tag, k), tx, exp_bit(b, k));
            if (k != NB - 1) @(negedge clk);
        end
    endtask

    // Mid-bit sampling receiver, as the core UART receiver would see the line.
    task automatic rx_byte(input logic [7:0] exp, input string tag);
        bit f;
        int w;
        logic [7:0] d;
        wait_start(4 * CPB, f, w);
        chk({tag, "_found"}, f, 1);
        repeat (CPB / 2) @(negedge clk);
        chk({tag, "_start"}, tx, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        chk({tag, "_parity"}, tx, ^exp);
`endif
        repeat (CPB) @(negedge clk);
        chk({tag, "_framing"}, tx, 1);
        chk({tag, "_data"}, d, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_ready", tx_ready, 1);

        // Single frame and push-to-start latency
        drive_push(8'h55);
        chk("t1_count", fifo_count, 1);
        chk("t1_busy", busy, 1);
        chk("t1_tx_idle", tx, 1);
        wait_start(10, found, waited);
        chk("t1_found", found, 1);
        chk("t1_latency_clk", waited + 1, 2);
        check_frame(8'h55, "t1");
        @(negedge clk);
        chk("t1_busy_end", busy, 0);
        chk("t1_tx_end", tx, 1);

        // Three frames back-to-back
        tx_data  = 8'hA3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h0F;
        @(negedge clk);
        chk("t2_count_pushpop", fifo_count, 1);
        tx_data = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t2_count", fifo_count, 2);
        chk("t2_fall", tx, 0);
        check_frame(8'hA3, "t2a");
        wait_start(CPB, found, waited);
        chk("t2_gap_ab", waited, 0);
        check_frame(8'h0F, "t2b");
        wait_start(CPB, found, waited);
        chk("t2_gap_bc", waited, 0);
        check_frame(8'hFF, "t2c");
        @(negedge clk);
        chk("t2_busy_end", busy, 0);

        // Hold tx_valid for six cycles: five accepted (one popped), the sixth refused
        for (int i = 0; i < 6; i++) begin
            tx_data  = 8'h10 + 8'(i);
            tx_valid = 1'b1;
            chk($sformatf("t3_ready%0d", i), tx_ready, (i < 5) ? 1 : 0);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("t3_count_full", fifo_count, 4);
        chk("t3_ready_full", tx_ready, 0);
        for (int i = 0; i < 5; i++) begin
            rx_byte(8'h10 + 8'(i), $sformatf("t3_rx%0d", i));
        end
        wait_start(3 * CPB, found, waited);
        chk("t3_no_extra", found, 0);
        chk("t3_busy_end", busy, 0);

        // Reset mid data bit discards frame and FIFO
        drive_push(8'h00);
        wait_start(10, found, waited);
        chk("t4_found", found, 1);
        repeat (CPB + CPB / 2) @(negedge clk);
        drive_push(8'h3C);
        chk("t4_count_pre", fifo_count, 1);
        chk("t4_tx_pre", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_tx", tx, 1);
        chk("t4_rst_count", fifo_count, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_ready", tx_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_start(3 * CPB, found, waited);
        chk("t4_discard", found, 0);
        drive_push(8'h81);
        wait_start(10, found, waited);
        chk("t4_latency_clk", waited + 1, 2);
        check_frame(8'h81, "t4");
        @(negedge clk);
        chk("t4_busy_end", busy, 0);

        // Parity-sensitive patterns (parity 1 and 0 respectively)
        drive_push(8'h07);
        wait_start(10, found, waited);
        chk("t5a_found", found, 1);
        check_frame(8'h07, "t5a");
        @(negedge clk);
        drive_push(8'h03);
        wait_start(10, found, waited);
        chk("t5b_found", found, 1);
        check_frame(8'h03, "t5b");

        // Loopback through a receiver for every byte value
        for (int b = 0; b < 256; b++) begin
            @(negedge clk);
            drive_push(8'(b));
            rx_byte(8'(b), $sformatf("lb%0d", b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
